// File: rtl/seq_detect_ctrl.sv
// seq_detect_ctrl: run controller for a programmable serial Mealy sequence
// detector. It holds the pattern, length, overlap and target configuration,
// arms and disarms detection, and counts matches on a gated serial stream.
module seq_detect_ctrl #(
    parameter int unsigned MAX_LEN = 8,
    parameter int unsigned CNT_W   = 8
) (
    input  logic                         clk,
    input  logic                         arstn,
    input  logic                         cfg_we,
    input  logic [MAX_LEN-1:0]           cfg_pattern,
    input  logic [$clog2(MAX_LEN+1)-1:0] cfg_len,
    input  logic                         cfg_overlap,
    input  logic [CNT_W-1:0]             cfg_target,
    input  logic                         start,
    input  logic                         abort,
    input  logic                         in_valid,
    input  logic                         in,
    output logic                         match,
    output logic [CNT_W-1:0]             match_count,
    output logic                         busy,
    output logic                         done,
    output logic                         err
);

    localparam int unsigned LW = $clog2(MAX_LEN + 1);
    localparam logic [LW-1:0] MAX_LEN_L = LW'(MAX_LEN);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [MAX_LEN-1:0]   pat_q, pat_d;
    logic [LW-1:0]        len_q, len_d;
    logic                 ovl_q, ovl_d;
    logic [CNT_W-1:0]     tgt_q, tgt_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [MAX_LEN-2:0]   hist_q, hist_d;
    logic [LW-1:0]        fill_q, fill_d;
    logic                 err_q, err_d;

    logic [MAX_LEN-1:0]   window;
    logic [MAX_LEN-1:0]   mask;
    logic                 hit;
    logic                 match_w;
    logic [CNT_W-1:0]     cnt_inc;
    logic [LW-1:0]        fill_inc;
    logic                 len_legal;

    // Match detection on the shifted-in window, masked to the programmed length
    always_comb begin
        window = {hist_q, in};
        mask   = '0;
        for (int unsigned i = 0; i < MAX_LEN; i++) begin
            mask[i] = (LW'(i) < len_q);
        end
        hit      = (({1'b0, fill_q} + (LW+1)'(1)) >= {1'b0, len_q}) &&
                   (((window ^ pat_q) & mask) == '0);
        match_w  = (state_q == RUN) && in_valid && hit && !abort;
        cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
        fill_inc = (fill_q == MAX_LEN_L) ? fill_q : fill_q + LW'(1);
        len_legal = (cfg_len != '0) && (cfg_len <= MAX_LEN_L);
    end

    // State register
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, DONE: if (start) state_d = RUN;
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (match_w && (tgt_q != '0) && (cnt_inc == tgt_q)) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from state and the live match term
    always_comb begin
        busy        = (state_q == RUN);
        done        = (state_q == DONE);
        match       = match_w;
        match_count = cnt_q;
        err         = err_q;
    end

    // Next-value logic for configuration, history, fill and counter
    always_comb begin
        pat_d  = pat_q;
        len_d  = len_q;
        ovl_d  = ovl_q;
        tgt_d  = tgt_q;
        cnt_d  = cnt_q;
        hist_d = hist_q;
        fill_d = fill_q;
        err_d  = cfg_we && ((state_q == RUN) || !len_legal);

        if (cfg_we && (state_q != RUN) && len_legal) begin
            pat_d = cfg_pattern;
            len_d = cfg_len;
            ovl_d = cfg_overlap;
            tgt_d = cfg_target;
        end

        if (start && (state_q != RUN)) begin
            cnt_d  = '0;
            hist_d = '0;
            fill_d = '0;
        end else if ((state_q == RUN) && in_valid && !abort) begin
            if (match_w) begin
                cnt_d = cnt_inc;
                if (ovl_q) begin
                    hist_d = window[MAX_LEN-2:0];
                    fill_d = fill_inc;
                end else begin
                    hist_d = '0;
                    fill_d = '0;
                end
            end else begin
                hist_d = window[MAX_LEN-2:0];
                fill_d = fill_inc;
            end
        end
    end

    // Datapath registers; configuration resets to pattern 101, length 3
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            pat_q  <= MAX_LEN'(5);
            len_q  <= LW'(3);
            ovl_q  <= 1'b0;
            tgt_q  <= '0;
            cnt_q  <= '0;
            hist_q <= '0;
            fill_q <= '0;
            err_q  <= 1'b0;
        end else begin
            pat_q  <= pat_d;
            len_q  <= len_d;
            ovl_q  <= ovl_d;
            tgt_q  <= tgt_d;
            cnt_q  <= cnt_d;
            hist_q <= hist_d;
            fill_q <= fill_d;
            err_q  <= err_d;
        end
    end

endmodule
